uart_rx_line: RTL and testbench

Synthesizable, parametrised UART receiver that replaces the fixed 8N1, 115200-baud behavioural receive model with clocked RTL. It oversamples the serial line, supports configurable data bits, parity and stop bits, and buffers received characters in a FIFO. Each byte carries an end-of-line tag, so downstream logic can assemble lines. It sits between the board RX pin and the command/display logic.

---
 rtl/uart_rx_line.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_line.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_line.sv
// Oversampling UART receiver with configurable framing and a show-ahead FIFO
// whose entries carry an end-of-line tag for downstream line assembly.
module uart_rx_line #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         DATA_BITS    = 8,
  parameter int         PARITY       = 0,
  parameter int         STOP_BITS    = 1,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] EOL_CHAR     = 8'h0A
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_eol,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]        FULL_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]        HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic [DATA_BITS-1:0] EOL_TAG   = EOL_CHAR[DATA_BITS-1:0];
  localparam logic [3:0]           LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic                 ODD_MODE  = (PARITY == 1);
  localparam logic [AW:0]          CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]          FIFO_ONE  = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  logic                 rx_meta, rx_sync;
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bit_idx, bit_n;
  logic                 stop_idx, stop_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bad, par_bad_n;
  logic                 push, frame_n, parity_n;
  logic                 tick;

  logic [DATA_BITS:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, pop, write;

  // Both flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      stop_idx   <= stop_n;
      shift      <= shift_n;
      par_bad    <= par_bad_n;
      frame_err  <= frame_n;
      parity_err <= parity_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    stop_n    = stop_idx;
    shift_n   = shift;
    par_bad_n = par_bad;
    push      = 1'b0;
    frame_n   = 1'b0;
    parity_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_sync) begin
          state_n = S_START;
          cnt_n   = HALF_BIT;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_n = cnt - CNT_ONE;
        end else if (!rx_sync) begin
          state_n   = S_DATA;
          cnt_n     = FULL_BIT;
          bit_n     = '0;
          par_bad_n = 1'b0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_n = cnt - CNT_ONE;
        end else begin
          shift_n = {rx_sync, shift[DATA_BITS-1:1]};
          cnt_n   = FULL_BIT;
          if (bit_idx == LAST_DATA) begin
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_n  = 1'b0;
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (!tick) begin
          cnt_n = cnt - CNT_ONE;
        end else begin
          par_bad_n = ((^shift) ^ rx_sync) != ODD_MODE;
          cnt_n     = FULL_BIT;
          state_n   = S_STOP;
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_n = cnt - CNT_ONE;
        end else if (!rx_sync) begin
          frame_n = 1'b1;
          state_n = S_WAIT_HIGH;
        end else if (stop_idx != LAST_STOP) begin
          stop_n = 1'b1;
          cnt_n  = FULL_BIT;
        end else if (par_bad) begin
          parity_n = 1'b1;
          state_n  = S_IDLE;
        end else begin
          push    = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_sync) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign rx_valid = (fifo_count != '0);
  assign pop      = rx_valid & rx_ready;
  assign full     = (fifo_count == CNT_FULL);
  assign write    = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= {shift == EOL_TAG, shift};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push & full & ~pop;
      if (write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({write, pop})
        2'b10:   fifo_count <= fifo_count + FIFO_ONE;
        2'b01:   fifo_count <= fifo_count - FIFO_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign rx_data = rx_valid ? mem[rd_ptr][DATA_BITS-1:0] : '0;
  assign rx_eol  = rx_valid & mem[rd_ptr][DATA_BITS];

endmodule

// File: tb/tb_uart_rx_line.sv
// Bench for uart_rx_line: an 8N1 instance (a) and a 7E2 instance (b), both
// with a 4-entry FIFO, checked against a queue-based model of received bytes.
module tb_uart_rx_line;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rx_a, ready_a;
  logic [7:0] data_a;
  logic       eol_a, valid_a, fe_sig_a, pe_sig_a, ov_sig_a;
  logic [2:0] count_a;

  logic       rst_b, rx_b, ready_b;
  logic [6:0] data_b;
  logic       eol_b, valid_b, fe_sig_b, pe_sig_b, ov_sig_b;
  logic [2:0] count_b;

  uart_rx_line #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(4), .EOL_CHAR(8'h0A)) dut_a (
    .clk(clk), .rst(rst_a), .rx(rx_a), .rx_data(data_a), .rx_eol(eol_a),
    .rx_valid(valid_a), .rx_ready(ready_a), .frame_err(fe_sig_a),
    .parity_err(pe_sig_a), .overrun(ov_sig_a), .fifo_count(count_a));

  uart_rx_line #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                 .FIFO_DEPTH(4), .EOL_CHAR(8'h0A)) dut_b (
    .clk(clk), .rst(rst_b), .rx(rx_b), .rx_data(data_b), .rx_eol(eol_b),
    .rx_valid(valid_b), .rx_ready(ready_b), .frame_err(fe_sig_b),
    .parity_err(pe_sig_b), .overrun(ov_sig_b), .fifo_count(count_b));

  int errors = 0;
  int checks = 0;
  int fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;
  logic [8:0] pops_a[$];
  logic [7:0] pops_b[$];
  logic [8:0] exp_a[$];
  logic [7:0] exp_b[$];

  // Pulse cycles and consumed entries, observed mid-cycle.
  always @(negedge clk) begin
    if (fe_sig_a) fe_a++;
    if (pe_sig_a) pe_a++;
    if (ov_sig_a) ov_a++;
    if (fe_sig_b) fe_b++;
    if (pe_sig_b) pe_b++;
    if (ov_sig_b) ov_b++;
    if (valid_a && ready_a) pops_a.push_back({eol_a, data_a});
    if (valid_b && ready_b) pops_b.push_back({eol_b, data_b});
  end

  task automatic clear_obs();
    fe_a = 0; pe_a = 0; ov_a = 0; fe_b = 0; pe_b = 0; ov_b = 0;
    pops_a.delete(); pops_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic drive_a(input logic b);
    rx_a = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic b);
    rx_b = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d);
    drive_a(1'b0);
    for (int i = 0; i < 8; i++) drive_a(d[i]);
    drive_a(1'b1);
  endtask

  // Even parity: the parity bit makes the total count of ones even.
  task automatic send_b(input logic [6:0] d, input bit bad_parity);
    drive_b(1'b0);
    for (int i = 0; i < 7; i++) drive_b(d[i]);
    drive_b((^d) ^ bad_parity);
    drive_b(1'b1);
    drive_b(1'b1);
  endtask

  task automatic compare_pops_a(input string name);
    checks++;
    if (pops_a.size() !== exp_a.size()) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d expected %0d", name, pops_a.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size(); i++) begin
      checks++;
      if (i >= pops_a.size()) begin
        errors++;
        $display("[TB] FAIL %s[%0d]: got none expected %h", name, i, exp_a[i]);
      end else if (pops_a[i] !== exp_a[i]) begin
        errors++;
        $display("[TB] FAIL %s[%0d]: got %h expected %h", name, i, pops_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({valid_a, eol_a, fe_sig_a, pe_sig_a, ov_sig_a, count_a, data_a} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_a: got v%b e%b f%b p%b o%b c%0d d%h expected all zero",
               valid_a, eol_a, fe_sig_a, pe_sig_a, ov_sig_a, count_a, data_a);
    end
    checks++;
    if ({valid_b, eol_b, fe_sig_b, pe_sig_b, ov_sig_b, count_b, data_b} !== 15'h0) begin
      errors++;
      $display("[TB] FAIL reset_b: got v%b e%b f%b p%b o%b c%0d d%h expected all zero",
               valid_b, eol_b, fe_sig_b, pe_sig_b, ov_sig_b, count_b, data_b);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_8n1_lines();
    clear_obs();
    ready_a = 1'b1;
    send_a(8'h41); send_a(8'h42); send_a(8'h0A);
    exp_a.push_back(9'h041); exp_a.push_back(9'h042); exp_a.push_back(9'h10A);
    drive_a(1'b1); drive_a(1'b1);
    compare_pops_a("line");
    checks++;
    if (fe_a + pe_a + ov_a !== 0) begin
      errors++;
      $display("[TB] FAIL line_errs: got fe%0d pe%0d ov%0d expected none", fe_a, pe_a, ov_a);
    end
  endtask

  // The byte lands at the centre of the stop bit: absent mid-frame, present at its end.
  task automatic test_latency();
    clear_obs();
    ready_a = 1'b0;
    fork
      send_a(8'h5A);
      begin
        repeat (CPB * 9 + CPB / 2 - 2) @(posedge clk);
        #1;
        checks++;
        if (valid_a !== 1'b0) begin
          errors++;
          $display("[TB] FAIL early_valid: got %b expected 0", valid_a);
        end
      end
    join
    checks++;
    if (valid_a !== 1'b1 || count_a !== 3'd1 || data_a !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL frame_end: got v%b c%0d d%h expected v1 c1 d5a", valid_a, count_a, data_a);
    end
    ready_a = 1'b1;
    drive_a(1'b1);
  endtask

  task automatic test_glitch_break();
    clear_obs();
    ready_a = 1'b1;
    rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    drive_a(1'b1); drive_a(1'b1); drive_a(1'b1);
    checks++;
    if (pops_a.size() !== 0 || fe_a + pe_a + ov_a !== 0) begin
      errors++;
      $display("[TB] FAIL glitch: got pops%0d errs%0d expected 0 0", pops_a.size(), fe_a + pe_a + ov_a);
    end
    rx_a = 1'b0;
    repeat (20 * CPB) @(posedge clk);
    #1;
    drive_a(1'b1); drive_a(1'b1);
    send_a(8'h55);
    drive_a(1'b1); drive_a(1'b1);
    checks++;
    if (fe_a !== 1) begin
      errors++;
      $display("[TB] FAIL break_fe: got %0d expected 1", fe_a);
    end
    exp_a.push_back(9'h055);
    compare_pops_a("after_break");
  endtask

  task automatic test_overrun();
    int ov_exp = 0;
    clear_obs();
    ready_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_a(8'(8'h10 + i));
      if (exp_a.size() < 4) exp_a.push_back({1'b0, 8'(8'h10 + i)});
      else ov_exp++;
    end
    drive_a(1'b1);
    checks++;
    if (count_a !== 3'd4 || ov_a !== ov_exp) begin
      errors++;
      $display("[TB] FAIL overrun: got c%0d ov%0d expected c4 ov%0d", count_a, ov_a, ov_exp);
    end
    ready_a = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    compare_pops_a("drain");
  endtask

  // Consumer pops on the very edge the next byte is pushed into a full FIFO.
  task automatic test_full_push();
    clear_obs();
    ready_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_a(8'(8'h20 + i));
      exp_a.push_back({1'b0, 8'(8'h20 + i)});
    end
    exp_a.push_back(9'h024);
    fork
      send_a(8'h24);
      begin
        repeat (CPB * 9 + CPB / 2 + 2) @(posedge clk);
        #1 ready_a = 1'b1;
        @(posedge clk);
        #1 ready_a = 1'b0;
      end
    join
    drive_a(1'b1);
    checks++;
    if (ov_a !== 0 || count_a !== 3'd4) begin
      errors++;
      $display("[TB] FAIL full_push: got ov%0d c%0d expected ov0 c4", ov_a, count_a);
    end
    ready_a = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    compare_pops_a("full_push_order");
  endtask

  task automatic test_reset_midframe();
    clear_obs();
    ready_a = 1'b0;
    send_a(8'h77);
    drive_a(1'b0);
    drive_a(1'b1); drive_a(1'b0); drive_a(1'b1);
    rst_a = 1'b1;
    rx_a  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({valid_a, eol_a, fe_sig_a, pe_sig_a, ov_sig_a, count_a, data_a} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL midframe_reset: got v%b e%b c%0d d%h expected all zero",
               valid_a, eol_a, count_a, data_a);
    end
    ready_a = 1'b1;
    drive_a(1'b1);
    send_a(8'h3C);
    drive_a(1'b1); drive_a(1'b1);
    exp_a.push_back(9'h03C);
    compare_pops_a("after_reset");
  endtask

  task automatic test_parity();
    clear_obs();
    ready_b = 1'b1;
    send_b(7'h35, 1'b0);
    drive_b(1'b1); drive_b(1'b1);
    checks++;
    if (pops_b.size() !== 1 || (pops_b.size() == 1 && pops_b[0] !== 8'h35) || pe_b !== 0) begin
      errors++;
      $display("[TB] FAIL parity_good: got pops%0d pe%0d expected 35 once pe0", pops_b.size(), pe_b);
    end
    ready_b = 1'b0;
    send_b(7'h35, 1'b1);
    drive_b(1'b1); drive_b(1'b1);
    checks++;
    if (pe_b !== 1 || count_b !== 3'd0 || fe_b !== 0) begin
      errors++;
      $display("[TB] FAIL parity_bad: got pe%0d c%0d fe%0d expected pe1 c0 fe0", pe_b, count_b, fe_b);
    end
  endtask

  task automatic test_random_b();
    int pe_exp = 0;
    logic [6:0] d;
    bit bad;
    clear_obs();
    ready_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d   = (i == 5) ? 7'h0A : 7'($urandom_range(0, 127));
      bad = ($urandom_range(0, 3) == 0);
      send_b(d, bad);
      if (bad) pe_exp++;
      else exp_b.push_back({d == 7'h0A, d});
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) drive_b(1'b1);
    end
    drive_b(1'b1); drive_b(1'b1);
    checks++;
    if (pe_b !== pe_exp || fe_b !== 0 || ov_b !== 0) begin
      errors++;
      $display("[TB] FAIL rand_errs: got pe%0d fe%0d ov%0d expected pe%0d fe0 ov0", pe_b, fe_b, ov_b, pe_exp);
    end
    checks++;
    if (pops_b.size() !== exp_b.size()) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d expected %0d", pops_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size(); i++) begin
      checks++;
      if (i >= pops_b.size() || pops_b[i] !== exp_b[i]) begin
        errors++;
        $display("[TB] FAIL rand[%0d]: got %h expected %h", i,
                 (i < pops_b.size()) ? pops_b[i] : 8'hxx, exp_b[i]);
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; rx_a = 1'b1; ready_a = 1'b0;
    rst_b = 1'b1; rx_b = 1'b1; ready_b = 1'b0;
    clear_obs();
    test_reset();
    test_8n1_lines();
    test_latency();
    test_glitch_break();
    test_overrun();
    test_full_push();
    test_reset_midframe();
    test_parity();
    test_random_b();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
